// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity unit.
package parity_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/xor_gate.sv
// Two-input XOR used as the parity accumulator's combining element.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/serial_parity_unit.sv
// Frame-based serial parity generator/checker: accumulates FRAME_LEN bits over a
// valid/ready handshake, then compares against a received parity bit.
module serial_parity_unit
  import parity_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic odd_sel,
  input  logic abort,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  input  logic par_in,
  input  logic par_valid,
  output logic parity_out,
  output logic err,
  output logic done,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  logic             acc;
  logic             acc_next;
  logic [CNT_W-1:0] cnt;
  logic             odd_q;

  xor_gate u_xor (
    .a (acc),
    .b (bit_in),
    .y (acc_next)
  );

  always_comb begin
    bit_ready = 1'b0;
    busy      = 1'b0;
    if (state == SHIFT) bit_ready = 1'b1;
    if (state != IDLE)  busy      = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= 1'b0;
      cnt        <= '0;
      odd_q      <= PAR_EVEN;
      parity_out <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            acc   <= 1'b0;
            cnt   <= '0;
            odd_q <= odd_sel;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
          end else if (bit_valid) begin
            acc <= acc_next;
            // The last bit leaves cnt at FRAME_LEN-1 so the counter never wraps.
            if (cnt == LAST_CNT) state <= CHECK;
            else                 cnt   <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (abort) begin
            state <= IDLE;
          end else if (par_valid) begin
            parity_out <= acc ^ odd_q;
            err        <= par_in ^ acc ^ odd_q;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_unit.sv
// Directed bench for serial_parity_unit with FRAME_LEN=8: frame table plus hand sequences.
module tb_serial_parity_unit;
  import parity_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, odd_sel = 1'b0, abort = 1'b0;
  logic bit_in = 1'b0, bit_valid = 1'b0, par_in = 1'b0, par_valid = 1'b0;
  logic bit_ready, parity_out, err, done, busy;

  int checks = 0;
  int errors = 0;

  serial_parity_unit #(.FRAME_LEN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .odd_sel    (odd_sel),
    .abort      (abort),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .par_in     (par_in),
    .par_valid  (par_valid),
    .parity_out (parity_out),
    .err        (err),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       odd;
    logic [7:0] bits;
    logic       par;
    logic       exp_par;
    logic       exp_err;
    int         stall_at;
  } frame_t;

  frame_t frames [7];

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic start_frame(input logic odd);
    @(negedge clk);
    start = 1'b1; odd_sel = odd;
    @(negedge clk);
    start = 1'b0; odd_sel = 1'b0;
    check("bit_ready_after_start", bit_ready, 1'b1);
  endtask

  // Sends the first n bits (index 0 first); optional stall and stray start pulse.
  task automatic send_bits(input logic [7:0] bits, input int n, input int stall_at, input int start_at);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in    = bits[i];
      start     = (i == start_at);
      @(negedge clk);
      bit_valid = 1'b0;
      start     = 1'b0;
      if (i == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          check("bit_ready_in_stall", bit_ready, 1'b1);
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic finish_frame(input logic par, input logic exp_par, input logic exp_err);
    check("bit_ready_in_check", bit_ready, 1'b0);
    check("busy_in_check", busy, 1'b1);
    check("no_done_before_par", done, 1'b0);
    par_valid = 1'b1; par_in = par;
    @(negedge clk);
    par_valid = 1'b0; par_in = 1'b0;
    check("done_pulse", done, 1'b1);
    check("parity_out", parity_out, exp_par);
    check("err", err, exp_err);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic done_low_after;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    frames[0] = '{1'b0, 8'h0D, 1'b1, 1'b1, 1'b0, -1};
    frames[1] = '{PAR_ODD, 8'h0D, 1'b1, 1'b0, 1'b1, -1};
    frames[2] = '{1'b0, 8'h0D, 1'b1, 1'b1, 1'b0, 3};
    frames[3] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, -1};
    frames[4] = '{PAR_ODD, 8'hFF, 1'b0, 1'b1, 1'b1, -1};
    frames[5] = '{PAR_ODD, 8'h80, 1'b0, 1'b0, 1'b0, -1};
    frames[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, -1};

    // Power-on reset
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_bit_ready", bit_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_parity_out", parity_out, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;

    // par_valid and bit_valid in IDLE are ignored
    @(negedge clk);
    par_valid = 1'b1; par_in = 1'b1; bit_valid = 1'b1;
    @(negedge clk);
    par_valid = 1'b0; par_in = 1'b0; bit_valid = 1'b0;
    check("idle_par_valid_no_done", done, 1'b0);
    check("idle_stays_idle", busy, 1'b0);

    for (int f = 0; f < 7; f++) begin
      start_frame(frames[f].odd);
      send_bits(frames[f].bits, 8, frames[f].stall_at, -1);
      finish_frame(frames[f].par, frames[f].exp_par, frames[f].exp_err);
      done_low_after();
    end

    // Odd frame leaves parity_out=0, err=1; abort after 4 bits keeps them
    start_frame(1'b1);
    send_bits(8'h0D, 8, -1, -1);
    finish_frame(1'b1, 1'b0, 1'b1);
    start_frame(1'b0);
    send_bits(8'h0D, 4, -1, -1);
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check("abort_shift_idle", busy, 1'b0);
    check("abort_shift_no_done", done, 1'b0);
    check("abort_shift_parity_kept", parity_out, 1'b0);
    check("abort_shift_err_kept", err, 1'b1);
    done_low_after();

    // Abort in CHECK beats a simultaneous par_valid
    start_frame(1'b0);
    send_bits(8'h01, 8, -1, -1);
    abort = 1'b1; par_valid = 1'b1; par_in = 1'b0;
    @(negedge clk);
    abort = 1'b0; par_valid = 1'b0;
    check("abort_check_idle", busy, 1'b0);
    check("abort_check_no_done", done, 1'b0);
    check("abort_check_err_kept", err, 1'b1);

    // All-zero even frame after abort
    start_frame(1'b0);
    send_bits(8'h00, 8, -1, -1);
    finish_frame(1'b0, 1'b0, 1'b0);
    done_low_after();

    // Stray start in SHIFT does not restart the frame
    start_frame(1'b0);
    send_bits(8'h03, 8, -1, 2);
    finish_frame(1'b1, 1'b0, 1'b1);

    // Back-to-back: start in the done cycle
    start = 1'b1; odd_sel = 1'b1;
    @(negedge clk);
    start = 1'b0; odd_sel = 1'b0;
    check("b2b_done_low", done, 1'b0);
    check("b2b_bit_ready", bit_ready, 1'b1);
    send_bits(8'h07, 8, -1, -1);
    finish_frame(1'b0, 1'b0, 1'b0);
    done_low_after();

    // Asynchronous reset mid-SHIFT after a frame with parity_out=1
    start_frame(1'b0);
    send_bits(8'h01, 8, -1, -1);
    finish_frame(1'b0, 1'b1, 1'b1);
    start_frame(1'b0);
    send_bits(8'hFF, 3, -1, -1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_bit_ready", bit_ready, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_parity_out", parity_out, 1'b0);
    check("midrst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_no_done", done, 1'b0);
      check("post_rst_idle", busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
